// File: rtl/monitor_pkg.sv
// Shared opcodes, reply bytes and FSM state encoding for the monitor programmer.
package monitor_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_DUMP  = 8'h44;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_LEN  = 3'd3,
        S_WR   = 3'd4,
        S_RD   = 3'd5,
        S_TX   = 3'd6
    } monitor_state_t;

endpackage

// File: rtl/monitor_timer.sv
// Inter-byte timeout: down-counter reloaded on clear or when idle, flags terminal count.
module monitor_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= LOAD;
        end else if (clear || !run) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A byte arriving on the terminal cycle wins over the timeout.
    assign expired = run && !clear && (count == '0);

endmodule

// File: rtl/monitor_programmer.sv
// Host byte-command engine driving the memory programmer port (write/read/dump).
// Optional inter-byte timeout compiled in with MONITOR_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for an opcode byte
// S_ADDR | waiting for the address byte
// S_DATA | waiting for the write data byte
// S_LEN  | waiting for the dump length byte
// S_WR   | single-cycle memory write strobe
// S_RD   | waiting READ_LATENCY cycles for read data
// S_TX   | holding a reply byte until the transmitter takes it
module monitor_programmer
    import monitor_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy
);

    localparam int RW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [RW-1:0] RD_LOAD = RW'(READ_LATENCY);

    monitor_state_t state;
    logic [7:0]     opcode;
    logic [8:0]     dump_cnt;
    logic           is_dump;
    logic [RW-1:0]  rd_wait;
    logic           timeout;

`ifdef MONITOR_TIMEOUT_EN
    logic waiting_byte;
    assign waiting_byte = (state == S_ADDR) || (state == S_DATA) || (state == S_LEN);

    monitor_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (rx_valid),
        .run     (waiting_byte),
        .expired (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            opcode   <= 8'h00;
            dump_cnt <= 9'd0;
            is_dump  <= 1'b0;
            rd_wait  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            prg_we   <= 1'b0;
            prg_MA   <= 8'h00;
            prg_WD   <= 8'h00;
        end else begin
            prg_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            OP_WRITE, OP_READ, OP_DUMP: begin
                                opcode <= rx_data;
                                state  <= S_ADDR;
                            end
                            default: begin
                                is_dump  <= 1'b0;
                                tx_data  <= RSP_NAK;
                                tx_valid <= 1'b1;
                                state    <= S_TX;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        prg_MA  <= rx_data;
                        rd_wait <= RD_LOAD;
                        is_dump <= 1'b0;
                        case (opcode)
                            OP_WRITE: state <= S_DATA;
                            OP_READ:  state <= S_RD;
                            default:  state <= S_LEN;
                        endcase
                    end
                end
                S_DATA: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        prg_WD <= rx_data;
                        prg_we <= 1'b1;
                        state  <= S_WR;
                    end
                end
                S_LEN: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        dump_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        is_dump  <= 1'b1;
                        rd_wait  <= RD_LOAD;
                        state    <= S_RD;
                    end
                end
                S_WR: begin
                    tx_data  <= RSP_ACK;
                    tx_valid <= 1'b1;
                    state    <= S_TX;
                end
                S_RD: begin
                    if (rd_wait == '0) begin
                        tx_data  <= prg_RD;
                        tx_valid <= 1'b1;
                        state    <= S_TX;
                    end else begin
                        rd_wait <= rd_wait - 1'b1;
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        // Every dump byte advances the address, so a full pass ends where it began.
                        if (is_dump) begin
                            prg_MA <= prg_MA + 8'd1;
                        end
                        if (is_dump && (dump_cnt > 9'd1)) begin
                            dump_cnt <= dump_cnt - 9'd1;
                            rd_wait  <= RD_LOAD;
                            state    <= S_RD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/monitor_programmer.md
# monitor_programmer

Byte-command engine that drives the programmer (monitor) port of the CDEC memory from a host serial link. It consumes received bytes from the UART receiver, decodes write/read/dump commands, performs the matching accesses on the `prg_*` memory port, and returns result bytes to the UART transmitter. It sits between the UART pair and the memory block; its clock also drives the memory's `prg_clock` at top level.

## Interface

**Parameters**
- `READ_LATENCY`, default 1: wait cycles between `prg_MA` being presented and `prg_RD` being valid.
- `TIMEOUT_CYCLES`, default 50_000_000: inter-byte timeout. Used only when the timeout feature is compiled in (see Configuration).

**Ports**
- `clock`, input, 1: system clock. Also connects to memory `prg_clock`.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `rx_valid`, input, 1: one-cycle pulse marking a received byte. There is no backpressure on this side.
- `rx_data`, input, 8: received byte.
- `tx_valid`, output, 1: response byte is pending.
- `tx_data`, output, 8: response byte.
- `tx_ready`, input, 1: transmitter accepts the byte in any cycle where `tx_valid` and `tx_ready` are both high.
- `prg_we`, output, 1: memory write enable.
- `prg_MA`, output, 8: memory address.
- `prg_WD`, output, 8: memory write data.
- `prg_RD`, input, 8: memory read data.
- `busy`, output, 1: high in every state except `S_IDLE`.

## Operation

**Commands (binary bytes):**
- `0x57` addr data: write `data` to `addr`, then reply `0x06` (ACK).
- `0x52` addr: reply with `mem[addr]`.
- `0x44` addr len: reply with `len` bytes starting at `addr`.
  - `len` = 0 means 256 bytes.
  - The address wraps from 0xFF to 0x00.
- Any other opcode: reply `0x15` (NAK) and return to `S_IDLE`.

**States and transitions:**
- `S_IDLE` → `S_ADDR` on a valid opcode, or → `S_TX` with NAK on an unknown opcode.
- `S_ADDR` → `S_DATA` for W, `S_RD` for R, `S_LEN` for D.
- `S_DATA` → `S_WR`.
- `S_LEN` → `S_RD`. The dump count is held in a 9-bit register: `len` = 0 loads 256.
- `S_WR`: `prg_we` is high for exactly one cycle, then → `S_TX` with ACK.
- `S_RD`: wait `READ_LATENCY` cycles, then capture `prg_RD` into `tx_data` and → `S_TX`.
- `S_TX`: hold `tx_valid` until accepted. Then:
  - Dump with count > 1: decrement the count, increment `prg_MA` (8-bit wrap), → `S_RD`.
  - Otherwise → `S_IDLE`.
- `rx_valid` pulses arriving in `S_WR`, `S_RD` or `S_TX` are discarded.

**Output rules:**
- `prg_MA` and `prg_WD` change only when the state machine loads them; they are held otherwise.
- `tx_data` is stable while `tx_valid` is high.

**Reset:**
- All outputs reset to 0: `tx_valid`, `tx_data`, `prg_we`, `prg_MA`, `prg_WD`, `busy`.
- Reset asserted mid-command or mid-dump aborts immediately. Any pending TX byte is dropped and no partial write occurs after reset.

## Timing

- **Write:** data byte sampled at edge e0 → `prg_we` high during the cycle after e0, for that cycle only. `tx_valid` (ACK) rises after edge e1.
- **Read**, with `READ_LATENCY` = 1: address byte sampled at e0 → `prg_MA` valid after e0 → `prg_RD` sampled at e2 → `tx_valid` high after e2. In general, capture happens `READ_LATENCY`+1 edges after `prg_MA` is updated.
- **Dump:** each byte acceptance at edge a → next address is presented after a → next `tx_valid` follows `READ_LATENCY`+1 edges later.
- **Acceptance:** a byte is accepted on the same edge where `tx_valid` and `tx_ready` are both high. `tx_valid` drops after that edge unless the next byte is already available.

## Configuration

- **`MONITOR_TIMEOUT_EN` defined:**
  - A counter clears on every `rx_valid` and runs while in `S_ADDR`, `S_DATA` or `S_LEN`.
  - When it reaches `TIMEOUT_CYCLES`-1, the machine returns to `S_IDLE` silently: no reply, and no memory access is performed.
- **Not defined:** there is no counter, and partial commands wait indefinitely.

## Structure

- **`monitor_pkg`** holds:
  - opcode constants `OP_WRITE`/`OP_READ`/`OP_DUMP`;
  - reply bytes `RSP_ACK`/`RSP_NAK`;
  - the state enum `monitor_state_t`.
- **`monitor_timer`** is the sub-module for the timeout counter. It has `clock`, `reset_n`, `clear`, `run` and `expired` ports, and is instantiated only under `MONITOR_TIMEOUT_EN`.

## Test plan

- **Write:** W 0x10 0xA5 → one-cycle `prg_we` with `prg_MA`=0x10 and `prg_WD`=0xA5; TX 0x06. Then R 0x10 → TX 0xA5.
- **Dump with wrap:** D 0xFE 0x03 over a model holding FE=0x11, FF=0x22, 00=0x33 → TX 0x11, 0x22, 0x33, then `busy`=0.
- **Dump of 256:** D 0x00 0x00 → exactly 256 bytes, `prg_MA` ends at 0x00. Hold `tx_ready` low for random cycles and check that `tx_data` stays stable while stalled.
- **Unknown opcode:** 0x99 → TX 0x15 and no `prg_we`. A byte sent during `S_TX` is ignored.
- **Timeout** (`MONITOR_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100): send W 0x20, then idle 100 cycles → `busy`=0 and no write. A following R 0x20 succeeds.
- **Reset mid-dump:** assert `reset_n`=0 in the middle of a dump → all outputs 0 immediately. After release, a new command works.
